// File: rtl/if_fetch_queue.sv
// Instruction-fetch stage with a DEPTH-entry prefetch queue feeding ID.
// Optional feature: define EARLY_JUMP_EN to resolve unconditional jumps in IF.
`ifndef EXEC
`define EXEC 1'b1
`endif
`ifndef JUMP
`define JUMP 5'b11111
`endif

module if_fetch_queue #(
    parameter int          PC_W     = 8,
    parameter int          IR_W     = 16,
    parameter int          DEPTH    = 4,
    parameter logic [PC_W-1:0] RESET_PC = '0,
    parameter logic [4:0]  OPC_JUMP = `JUMP
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       state,
    input  logic                       redirect,
    input  logic [PC_W-1:0]            redirect_pc,
    input  logic                       stall,
    input  logic [IR_W-1:0]            i_datain,
    output logic [PC_W-1:0]            i_addr,
    output logic [IR_W-1:0]            id_ir,
    output logic [PC_W-1:0]            id_pc,
    output logic                       id_valid,
    output logic [$clog2(DEPTH):0]     q_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int EW = PC_W + IR_W;

    logic [EW-1:0]   r_mem [DEPTH];
    logic [AW-1:0]   r_rd;
    logic [AW-1:0]   r_wr;
    logic [CW-1:0]   r_cnt;
    logic [PC_W-1:0] r_pc;
    logic [IR_W-1:0] r_id_ir;
    logic [PC_W-1:0] r_id_pc;
    logic            r_id_valid;

    logic            w_run;
    logic            w_pop;
    logic            w_fetch;
    logic            w_jump;
    logic            w_push;
    logic [PC_W-1:0] w_pc_nxt;
    logic [EW-1:0]   w_head;

    assign w_run   = (state == `EXEC);
    assign w_pop   = w_run && !redirect && !stall && (r_cnt != '0);
    assign w_fetch = w_run && !redirect &&
                     ((r_cnt < CW'(DEPTH)) || w_pop);
`ifdef EARLY_JUMP_EN
    assign w_jump  = (i_datain[IR_W-1 -: 5] == OPC_JUMP);
`else
    assign w_jump  = 1'b0;
`endif
    assign w_push  = w_fetch && !w_jump;
    assign w_head  = r_mem[r_rd];

    // An early jump replaces the sequential increment with the embedded target.
    always_comb begin
        w_pc_nxt = r_pc + PC_W'(1);
        if (w_jump) w_pc_nxt = i_datain[PC_W-1:0];
    end

    always_ff @(posedge clock) begin
        if (w_push) r_mem[r_wr] <= {r_pc, i_datain};
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_pc       <= RESET_PC;
            r_rd       <= '0;
            r_wr       <= '0;
            r_cnt      <= '0;
            r_id_ir    <= '0;
            r_id_pc    <= '0;
            r_id_valid <= 1'b0;
        end else if (w_run) begin
            if (redirect) begin
                r_pc       <= redirect_pc;
                r_rd       <= '0;
                r_wr       <= '0;
                r_cnt      <= '0;
                r_id_ir    <= '0;
                r_id_valid <= 1'b0;
            end else begin
                if (w_pop) begin
                    r_id_pc    <= w_head[EW-1:IR_W];
                    r_id_ir    <= w_head[IR_W-1:0];
                    r_id_valid <= 1'b1;
                    r_rd       <= r_rd + AW'(1);
                end else if (!stall) begin
                    r_id_ir    <= '0;
                    r_id_valid <= 1'b0;
                end
                if (w_fetch) r_pc <= w_pc_nxt;
                if (w_push)  r_wr <= r_wr + AW'(1);
                r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
            end
        end
    end

    assign i_addr   = r_pc;
    assign id_ir    = r_id_ir;
    assign id_pc    = r_id_pc;
    assign id_valid = r_id_valid;
    assign q_count  = r_cnt;

endmodule

// File: tb/tb_if_fetch_queue.sv
// Scoreboard bench for if_fetch_queue: queue-based reference model,
// directed scenarios followed by randomized run/stall/redirect/reset traffic.
`ifndef EXEC
`define EXEC 1'b1
`endif
`ifndef JUMP
`define JUMP 5'b11111
`endif

module tb_if_fetch_queue;

    localparam int DEPTH = 4;
    localparam logic [4:0] OPC = `JUMP;

    logic        clock;
    logic        reset;
    logic        state;
    logic        redirect;
    logic [7:0]  redirect_pc;
    logic        stall;
    logic [15:0] i_datain;
    logic [7:0]  i_addr;
    logic [15:0] id_ir;
    logic [7:0]  id_pc;
    logic        id_valid;
    logic [2:0]  q_count;

    if_fetch_queue #(.PC_W(8), .IR_W(16), .DEPTH(DEPTH),
                     .RESET_PC(8'h00), .OPC_JUMP(OPC)) dut (
        .clock(clock), .reset(reset), .state(state),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .stall(stall), .i_datain(i_datain), .i_addr(i_addr),
        .id_ir(id_ir), .id_pc(id_pc), .id_valid(id_valid),
        .q_count(q_count)
    );

    logic [15:0] mem [256];
    assign i_datain = mem[i_addr];

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct packed {
        logic [7:0]  addr;
        logic [15:0] ir;
        logic [7:0]  pc;
        logic        valid;
        logic [2:0]  cnt;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    // Reference model: program counter plus a plain queue of {pc, word}.
    logic [7:0]  m_pc = 8'h00;
    logic [23:0] m_q[$];
    logic [15:0] m_ir = '0;
    logic [7:0]  m_idpc = '0;
    logic        m_valid = 1'b0;

    function automatic bit is_jump(logic [15:0] w);
`ifdef EARLY_JUMP_EN
        return w[15:11] == OPC;
`else
        return 1'b0;
`endif
    endfunction

    task automatic model_step();
        logic [23:0] e;
        logic [15:0] w;
        bit          popped;
        if (!reset) begin
            m_pc = 8'h00; m_q.delete();
            m_ir = '0; m_idpc = '0; m_valid = 1'b0;
        end else if (state == `EXEC) begin
            if (redirect) begin
                m_pc = redirect_pc; m_q.delete();
                m_ir = '0; m_valid = 1'b0;
            end else begin
                popped = !stall && m_q.size() > 0;
                if (!stall) begin
                    if (m_q.size() > 0) begin
                        e = m_q.pop_front();
                        m_idpc = e[23:16]; m_ir = e[15:0]; m_valid = 1'b1;
                    end else begin
                        m_ir = '0; m_valid = 1'b0;
                    end
                end
                if (m_q.size() < DEPTH || (popped && m_q.size() < DEPTH + 1)) begin
                    w = mem[m_pc];
                    if (is_jump(w)) m_pc = w[7:0];
                    else begin
                        m_q.push_back({m_pc, w});
                        m_pc = m_pc + 8'd1;
                    end
                end
            end
        end
        exp_q.push_back('{addr: m_pc, ir: m_ir, pc: m_idpc,
                          valid: m_valid, cnt: 3'(m_q.size())});
    endtask

    task automatic drive(input logic rst, input logic st, input logic stl,
                         input logic rd, input logic [7:0] rpc);
        @(negedge clock);
        reset = rst; state = st; stall = stl;
        redirect = rd; redirect_pc = rpc;
        model_step();
    endtask

    task automatic run(input int n, input logic stl);
        for (int i = 0; i < n; i++) drive(1'b1, `EXEC, stl, 1'b0, 8'h00);
    endtask

    // Monitor: compares DUT outputs after each edge against the oldest expectation.
    always @(posedge clock) begin
        exp_t x;
        #1;
        if (exp_q.size() > 0) begin
            x = exp_q.pop_front();
            n_vec++;
            if (i_addr !== x.addr) begin
                n_err++;
                $display("FAIL i_addr t=%0t got %h exp %h", $time, i_addr, x.addr);
            end
            if (q_count !== x.cnt) begin
                n_err++;
                $display("FAIL q_count t=%0t got %0d exp %0d", $time, q_count, x.cnt);
            end
            if (id_valid !== x.valid) begin
                n_err++;
                $display("FAIL id_valid t=%0t got %b exp %b", $time, id_valid, x.valid);
            end
            if (id_ir !== x.ir) begin
                n_err++;
                $display("FAIL id_ir t=%0t got %h exp %h", $time, id_ir, x.ir);
            end
            if (id_pc !== x.pc) begin
                n_err++;
                $display("FAIL id_pc t=%0t got %h exp %h", $time, id_pc, x.pc);
            end
        end
    end

    initial begin
        int wait_cyc;
        reset = 1'b0; state = 1'b0; stall = 1'b0;
        redirect = 1'b0; redirect_pc = '0;
        for (int i = 0; i < 256; i++) mem[i] = 16'h0100 + 16'(i);
`ifdef EARLY_JUMP_EN
        mem[3]    = {OPC, 3'b000, 8'h20};
        mem[8'h58] = {OPC, 3'b000, 8'h10};
`endif

        drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        run(10, 1'b0);
        run(6, 1'b1);
        run(6, 1'b0);
        run(6, 1'b1);
        drive(1'b1, `EXEC, 1'b1, 1'b1, 8'h40);
        run(6, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b1, 8'h99);
        run(3, 1'b0);
        drive(1'b1, `EXEC, 1'b0, 1'b1, 8'hFC);
        run(8, 1'b0);
        run(3, 1'b1);
        drive(1'b0, `EXEC, 1'b0, 1'b0, 8'h00);
        run(6, 1'b0);

        for (int i = 0; i < 3000; i++) begin
            logic rst, st, stl, rd;
            rst = ($urandom_range(0, 199) != 0);
            st  = ($urandom_range(0, 9) != 0) ? `EXEC : ~`EXEC;
            stl = ($urandom_range(0, 2) == 0);
            rd  = ($urandom_range(0, 19) == 0);
            drive(rst, st, stl, rd, 8'($urandom));
        end

        wait_cyc = 0;
        while (exp_q.size() > 0 && wait_cyc < 10) begin
            @(posedge clock);
            wait_cyc++;
        end
        #2;
        if (exp_q.size() > 0) begin
            n_err++;
            $display("FAIL drain timeout pending %0d exp 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
